// File: rtl/decode_pkg.sv
// Shared constants for the RV32IM decode-and-dispatch stage: opcodes,
// the MULDIV funct7 encoding and the dispatch class bit positions.
package decode_pkg;

    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam int unsigned CLS_ALU = 4;
    localparam int unsigned CLS_LSU = 3;
    localparam int unsigned CLS_MUL = 2;
    localparam int unsigned CLS_DIV = 1;
    localparam int unsigned CLS_BR  = 0;

    function automatic logic [4:0] cls_onehot(input int unsigned idx);
        return 5'b00001 << idx;
    endfunction

endpackage

// File: rtl/decode_class.sv
// Combinational classifier: maps one RV32IM instruction word to a one-hot
// execution class, or flags it illegal (class bits all zero in that case).
module decode_class
    import decode_pkg::*;
#(
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic [31:0] i_inst,
    output logic [4:0]  o_class,
    output logic        o_illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_unused;

    assign w_opcode = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];
    assign w_funct7 = i_inst[31:25];
    assign w_unused = ^{i_inst[24:15], i_inst[11:7]};

    // Opcode / funct decode into the five dispatch classes
    always_comb begin
        o_class   = 5'b00000;
        o_illegal = 1'b0;
        case (w_opcode)
            OP_OP_IMM, OP_LUI, OP_AUIPC: o_class = cls_onehot(CLS_ALU);
            OP_OP: begin
                if (w_funct7 != FUNCT7_MULDIV) begin
                    o_class = cls_onehot(CLS_ALU);
                end else if (MULDIV_EN == 1'b0) begin
                    o_illegal = 1'b1;
                end else if (w_funct3[2] == 1'b1) begin
                    o_class = cls_onehot(CLS_DIV);
                end else begin
                    o_class = cls_onehot(CLS_MUL);
                end
            end
            OP_JAL, OP_JALR, OP_BRANCH: o_class = cls_onehot(CLS_BR);
            OP_LOAD, OP_STORE:          o_class = cls_onehot(CLS_LSU);
            default:                    o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_dispatch.sv
// In-order instruction FIFO whose head is classified and handed to one of five
// execution classes over valid/ready; illegal heads are reported and dropped.
module decode_dispatch
    import decode_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       inst_valid_i,
    input  logic [31:0]                inst_i,
    input  logic [31:0]                pc_i,
    output logic                       inst_ready_o,
    output logic [4:0]                 disp_valid_o,
    input  logic [4:0]                 disp_ready_i,
    output logic [31:0]                disp_inst_o,
    output logic [31:0]                disp_pc_o,
    output logic                       illegal_o,
    output logic [31:0]                illegal_pc_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   r_inst_mem [DEPTH];
    logic [31:0]   r_pc_mem   [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic [31:0] w_head_inst;
    logic [31:0] w_head_pc;
    logic [4:0]  w_class;
    logic        w_illegal;
    logic        w_nonempty;
    logic        w_push;
    logic        w_pop;

    assign w_head_inst = r_inst_mem[r_rptr];
    assign w_head_pc   = r_pc_mem[r_rptr];
    assign w_nonempty  = (r_count != {CW{1'b0}});

    decode_class #(
        .MULDIV_EN (MULDIV_EN)
    ) u_decode_class (
        .i_inst    (w_head_inst),
        .o_class   (w_class),
        .o_illegal (w_illegal)
    );

    // No full-bypass: a full FIFO refuses pushes even when the head pops
    assign inst_ready_o = (r_count != CW'(DEPTH));
    assign disp_valid_o = (w_nonempty && !w_illegal) ? w_class : 5'b00000;
    assign illegal_o    = w_nonempty && w_illegal;
    assign illegal_pc_o = w_head_pc;
    assign disp_inst_o  = w_head_inst;
    assign disp_pc_o    = w_head_pc;
    assign count_o      = r_count;

    assign w_push = inst_valid_i && inst_ready_o && !flush_i;
    assign w_pop  = illegal_o || ((disp_valid_o & disp_ready_i) != 5'b00000);

    // Entry storage; contents need no reset because occupancy gates every use
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_inst_mem[r_wptr] <= inst_i;
            r_pc_mem[r_wptr]   <= pc_i;
        end
    end

    // Pointer and occupancy tracking; flush wins over push and pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else if (flush_i) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_dispatch.sv
// Randomized and directed bench for decode_dispatch: two instances (MULDIV
// enabled / disabled) share stimulus and are each tracked by a queue model.
module tb_decode_dispatch;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        iv;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  rdy;

    logic        ir  [2];
    logic [4:0]  dv  [2];
    logic [31:0] di  [2];
    logic [31:0] dp  [2];
    logic        il  [2];
    logic [31:0] ip  [2];
    logic [2:0]  cnt [2];

    logic [63:0] mq [2][$];
    logic [31:0] itab [12];

    int checks   = 0;
    int failures = 0;

    decode_dispatch #(.DEPTH(DEPTH), .MULDIV_EN(1'b1)) u_dut_md (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .inst_valid_i(iv), .inst_i(inst), .pc_i(pc),
        .inst_ready_o(ir[0]), .disp_valid_o(dv[0]), .disp_ready_i(rdy),
        .disp_inst_o(di[0]), .disp_pc_o(dp[0]),
        .illegal_o(il[0]), .illegal_pc_o(ip[0]), .count_o(cnt[0])
    );

    decode_dispatch #(.DEPTH(DEPTH), .MULDIV_EN(1'b0)) u_dut_nomd (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .inst_valid_i(iv), .inst_i(inst), .pc_i(pc),
        .inst_ready_o(ir[1]), .disp_valid_o(dv[1]), .disp_ready_i(rdy),
        .disp_inst_o(di[1]), .disp_pc_o(dp[1]),
        .illegal_o(il[1]), .illegal_pc_o(ip[1]), .count_o(cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference classification straight from the RV32IM class table: {illegal, class}
    function automatic logic [5:0] ref_class(input logic [31:0] ins, input bit md);
        case (ins[6:0])
            7'h13, 7'h37, 7'h17: return {1'b0, 5'b10000};
            7'h33: begin
                if (ins[31:25] != 7'h01) return {1'b0, 5'b10000};
                if (!md)                 return {1'b1, 5'b00000};
                return ins[14] ? {1'b0, 5'b00010} : {1'b0, 5'b00100};
            end
            7'h6F, 7'h67, 7'h63: return {1'b0, 5'b00001};
            7'h03, 7'h23:        return {1'b0, 5'b01000};
            default:             return {1'b1, 5'b00000};
        endcase
    endfunction

    // Check both DUTs against their models, apply one cycle of stimulus, advance
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] p,
                        input logic [4:0] r, input bit fl);
        bit          exp_il [2];
        logic [4:0]  exp_dv [2];
        int          n      [2];
        for (int k = 0; k < 2; k++) begin
            logic [63:0] head;
            logic [5:0]  c;
            n[k] = mq[k].size();
            head = (n[k] > 0) ? mq[k][0] : 64'd0;
            c = ref_class(head[63:32], k == 0);
            exp_il[k] = (n[k] > 0) && c[5];
            exp_dv[k] = (n[k] > 0 && !c[5]) ? c[4:0] : 5'b00000;
            check_eq($sformatf("d%0d_count", k), 64'(cnt[k]), 64'(n[k]));
            check_eq($sformatf("d%0d_ready", k), 64'(ir[k]), 64'(n[k] < DEPTH));
            check_eq($sformatf("d%0d_disp_valid", k), 64'(dv[k]), 64'(exp_dv[k]));
            check_eq($sformatf("d%0d_illegal", k), 64'(il[k]), 64'(exp_il[k]));
            if (exp_dv[k] != 5'b00000) begin
                check_eq($sformatf("d%0d_disp_inst", k), 64'(di[k]), 64'(head[63:32]));
                check_eq($sformatf("d%0d_disp_pc", k), 64'(dp[k]), 64'(head[31:0]));
            end
            if (exp_il[k]) begin
                check_eq($sformatf("d%0d_illegal_pc", k), 64'(ip[k]), 64'(head[31:0]));
            end
        end
        iv = v; inst = ins; pc = p; rdy = r; flush = fl;
        for (int k = 0; k < 2; k++) begin
            bit do_pop;
            bit do_push;
            do_pop  = exp_il[k] || ((exp_dv[k] & r) != 5'b00000);
            do_push = v && (n[k] < DEPTH) && !fl;
            if (fl) begin
                mq[k].delete();
            end else begin
                if (do_pop)  void'(mq[k].pop_front());
                if (do_push) mq[k].push_back({ins, p});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] r, input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 32'h0, 32'h0, r, 1'b0);
    endtask

    initial begin
        itab[0]  = 32'h00500093; // ADDI
        itab[1]  = 32'h02208033; // MUL
        itab[2]  = 32'h0220D033; // DIVU
        itab[3]  = 32'h0000A103; // LW
        itab[4]  = 32'h0020A023; // SW
        itab[5]  = 32'h00208063; // BEQ
        itab[6]  = 32'h008000EF; // JAL
        itab[7]  = 32'h000080E7; // JALR
        itab[8]  = 32'h000012B7; // LUI
        itab[9]  = 32'h00001297; // AUIPC
        itab[10] = 32'h002081B3; // ADD
        itab[11] = 32'h0000007F; // unknown opcode

        rst_n = 1'b0; flush = 1'b0; iv = 1'b0; inst = 32'h0; pc = 32'h0; rdy = 5'b00000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ADDI single push and pop
        step(1'b1, 32'h00500093, 32'h100, 5'b10000, 1'b0);
        idle(5'b10000, 2);

        // MUL then DIVU with only MUL ready; DIV holds until its ready rises
        step(1'b1, 32'h02208033, 32'h104, 5'b00100, 1'b0);
        step(1'b1, 32'h0220D033, 32'h108, 5'b00100, 1'b0);
        idle(5'b00100, 3);
        idle(5'b00010, 2);

        // MUL at 0x200: illegal on the MULDIV-disabled instance
        step(1'b1, 32'h02208033, 32'h200, 5'b00000, 1'b0);
        idle(5'b00100, 2);

        // Six LW into a four-entry FIFO, then drain with wrap
        for (int i = 0; i < 6; i++) step(1'b1, 32'h0000A103, 32'h300 + 32'(4 * i), 5'b00000, 1'b0);
        idle(5'b01000, 6);

        // Fill three, flush together with a push
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0000A103, 32'h400 + 32'(4 * i), 5'b00000, 1'b0);
        step(1'b1, 32'h00500093, 32'h500, 5'b00000, 1'b1);
        idle(5'b00000, 1);

        // BEQ, JAL, unknown: BEQ stalls the younger entries until BR is ready
        step(1'b1, 32'h00208063, 32'h600, 5'b11110, 1'b0);
        step(1'b1, 32'h008000EF, 32'h604, 5'b11110, 1'b0);
        step(1'b1, 32'h0000007F, 32'h608, 5'b11110, 1'b0);
        idle(5'b11110, 2);
        idle(5'b00001, 4);

        // Flush in the cycle an illegal head is dropped
        step(1'b1, 32'h0000007F, 32'h700, 5'b00000, 1'b0);
        step(1'b0, 32'h0, 32'h0, 5'b00000, 1'b1);
        idle(5'b00000, 1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] ri;
            ri = ($urandom_range(0, 7) == 0) ? $urandom : itab[$urandom_range(0, 11)];
            step($urandom_range(0, 9) < 7, ri, $urandom & 32'hFFFF_FFFC,
                 5'($urandom_range(0, 31)), $urandom_range(0, 39) == 0);
        end

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0000A103, 32'h800 + 32'(4 * i), 5'b00000, 1'b0);
        iv = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("d%0d_async_rst_count", k), 64'(cnt[k]), 64'd0);
            check_eq($sformatf("d%0d_async_rst_valid", k), 64'(dv[k]), 64'd0);
            check_eq($sformatf("d%0d_async_rst_illegal", k), 64'(il[k]), 64'd0);
            mq[k].delete();
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5'b11111, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
